// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - icache miss/uncached refill controller issuing one AXI4 read burst per request
// Cached misses assemble a full line for the data array; uncached fetches return a single beat.
module icache_refill_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              miss,
    input  logic              uc_req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              lru,
    output logic              busy,
    output logic              refresh,
    output logic [1:0]        line_we,
    output logic [5:0]        line_index,
    output logic [LINE_W-1:0] line_data,
    output logic              uc_valid,
    output logic [DATA_W-1:0] uc_data,
    output logic              bus_err,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    input  logic              rlast,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp
);

    localparam int BEATS    = LINE_W / DATA_W;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_OFF = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);
    localparam logic [ADDR_W-1:0] BEAT_MASK = ~ADDR_W'(DATA_W / 8 - 1);
    localparam logic [7:0]        LEN_LINE  = 8'(BEATS - 1);
    localparam logic [2:0]        SIZE_BEAT = 3'($clog2(DATA_W / 8));
    localparam logic [1:0]        BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [ADDR_W-1:0]  addr_q;
    logic               lru_q;
    logic               cached_q;
    logic               stale_q;
    logic               err_q;
    logic [CNT_W-1:0]   beat_cnt;
    logic [DATA_W-1:0]  slot_q [BEATS];
    logic               accept;
    logic               stale;

    assign accept = (state == S_IDLE) && (miss || uc_req) && !flush;
    // A flush landing in the DONE cycle itself still kills the write/return.
    assign stale  = stale_q || flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            lru_q    <= 1'b0;
            cached_q <= 1'b0;
            stale_q  <= 1'b0;
            err_q    <= 1'b0;
            beat_cnt <= '0;
            for (int i = 0; i < BEATS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                lru_q    <= lru;
                cached_q <= miss;
                stale_q  <= 1'b0;
                err_q    <= 1'b0;
                beat_cnt <= '0;
            end else if (state != S_IDLE && flush) begin
                stale_q <= 1'b1;
            end
            // rlast ends the burst; beat_cnt simply wraps if the slave sends extra beats
            if (state == S_R && rvalid) begin
                slot_q[beat_cnt] <= rdata;
                beat_cnt         <= beat_cnt + 1'b1;
                err_q            <= err_q | (rresp != 2'b00);
            end
        end
    end

    always_comb begin
        state_nx = state;
        arvalid  = 1'b0;
        rready   = 1'b0;
        refresh  = 1'b0;
        uc_valid = 1'b0;
        bus_err  = 1'b0;
        line_we  = 2'b00;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_nx = S_R;
                end
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid && rlast) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                if (err_q) begin
                    bus_err = 1'b1;
                end else if (!stale) begin
                    if (cached_q) begin
                        refresh        = 1'b1;
                        line_we[lru_q] = 1'b1;
                    end else begin
                        uc_valid = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign araddr  = (state == S_AR) ? (addr_q & (cached_q ? LINE_MASK : BEAT_MASK)) : '0;
    assign arlen   = (state == S_AR && cached_q) ? LEN_LINE : 8'd0;
    assign arsize  = (state == S_AR) ? SIZE_BEAT : 3'd0;
    assign arburst = (state == S_AR) ? BURST_INCR : 2'b00;

    assign line_index = addr_q[LINE_OFF+5:LINE_OFF];
    assign uc_data    = slot_q[0];

    for (genvar g = 0; g < BEATS; g++) begin : g_line
        assign line_data[g*DATA_W +: DATA_W] = slot_q[g];
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         miss;
    logic         uc_req;
    logic [63:0]  req_addr;
    logic         lru;
    logic         busy;
    logic         refresh;
    logic [1:0]   line_we;
    logic [5:0]   line_index;
    logic [127:0] line_data;
    logic         uc_valid;
    logic [63:0]  uc_data;
    logic         bus_err;
    logic         arvalid;
    logic         arready;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rvalid;
    logic         rlast;
    logic         rready;
    logic [63:0]  rdata;
    logic [1:0]   rresp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .miss       (miss),
        .uc_req     (uc_req),
        .req_addr   (req_addr),
        .lru        (lru),
        .busy       (busy),
        .refresh    (refresh),
        .line_we    (line_we),
        .line_index (line_index),
        .line_data  (line_data),
        .uc_valid   (uc_valid),
        .uc_data    (uc_data),
        .bus_err    (bus_err),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .rvalid     (rvalid),
        .rlast      (rlast),
        .rready     (rready),
        .rdata      (rdata),
        .rresp      (rresp)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input logic [63:0] addr, input logic l, input logic m, input logic u);
        req_addr = addr;
        lru      = l;
        miss     = m;
        uc_req   = u;
        check("idle_busy", busy, 1'b0);
        step();
        miss   = 1'b0;
        uc_req = 1'b0;
    endtask

    task automatic ar_phase(input int delay, input logic [63:0] exp_addr, input logic [7:0] exp_len);
        for (int i = 0; i < delay; i++) begin
            arready = 1'b0;
            check("ar_wait_valid", arvalid, 1'b1);
            check("ar_wait_addr", araddr, exp_addr);
            check("ar_wait_len", arlen, exp_len);
            step();
        end
        arready = 1'b1;
        check("ar_valid", arvalid, 1'b1);
        check("ar_addr", araddr, exp_addr);
        check("ar_len", arlen, exp_len);
        check("ar_size", arsize, 3'd3);
        check("ar_burst", arburst, 2'b01);
        check("ar_busy", busy, 1'b1);
        step();
        arready = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic [1:0] resp, input logic last, input int gaps);
        for (int i = 0; i < gaps; i++) begin
            rvalid = 1'b0;
            check("gap_rready", rready, 1'b1);
            check("gap_refresh", refresh, 1'b0);
            step();
        end
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        check("beat_rready", rready, 1'b1);
        step();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; miss = 1'b0; uc_req = 1'b0; req_addr = '0; lru = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
        step();
        step();
        rst = 1'b0;

        check("rst_busy", busy, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_araddr", araddr, 64'h0);
        check("rst_rready", rready, 1'b0);
        check("rst_refresh", refresh, 1'b0);
        check("rst_line_we", line_we, 2'b00);
        check("rst_line_data", line_data, 128'h0);
        check("rst_uc", {uc_valid, bus_err}, 2'b00);
        check("rst_uc_data", uc_data, 64'h0);

        // cached miss, zero-wait slave: refresh on 4th cycle after accept
        accept(64'h8000_0128, 1'b1, 1'b1, 1'b0);
        ar_phase(0, 64'h8000_0120, 8'd1);
        beat(64'hA, 2'b00, 1'b0, 0);
        beat(64'hB, 2'b00, 1'b1, 0);
        check("c_refresh", refresh, 1'b1);
        check("c_line_we", line_we, 2'b10);
        check("c_line_data", line_data, {64'hB, 64'hA});
        check("c_line_index", line_index, 6'h12);
        check("c_uc_valid", uc_valid, 1'b0);
        check("c_done_busy", busy, 1'b1);
        step();
        check("c_after_busy", busy, 1'b0);
        check("c_after_refresh", refresh, 1'b0);

        // uncached with arready delayed; a miss during the wait is ignored
        accept(64'h1000_0004, 1'b0, 1'b0, 1'b1);
        miss = 1'b1;
        req_addr = 64'h5555_5550;
        ar_phase(3, 64'h1000_0000, 8'd0);
        miss = 1'b0;
        beat(64'h1122_3344_5566_7788, 2'b00, 1'b1, 0);
        check("u_valid", uc_valid, 1'b1);
        check("u_data", uc_data, 64'h1122_3344_5566_7788);
        check("u_refresh", {refresh, line_we}, 3'b000);
        step();
        check("u_after", {busy, uc_valid, arvalid}, 3'b000);

        // flush during beat 0: burst drained, no write
        accept(64'h8000_0200, 1'b0, 1'b1, 1'b0);
        ar_phase(0, 64'h8000_0200, 8'd1);
        flush = 1'b1;
        beat(64'h1, 2'b00, 1'b0, 0);
        flush = 1'b0;
        beat(64'h2, 2'b00, 1'b1, 0);
        check("f_done_busy", busy, 1'b1);
        check("f_refresh", {refresh, line_we, uc_valid, bus_err}, 5'b0);
        step();
        check("f_after_busy", busy, 1'b0);

        // SLVERR on beat 1
        accept(64'h8000_0300, 1'b1, 1'b1, 1'b0);
        ar_phase(0, 64'h8000_0300, 8'd1);
        beat(64'h3, 2'b00, 1'b0, 0);
        beat(64'h4, 2'b10, 1'b1, 0);
        check("e_bus_err", bus_err, 1'b1);
        check("e_refresh", {refresh, line_we}, 3'b000);
        step();
        check("e_after", {bus_err, busy}, 2'b00);

        // rvalid gaps between beats
        accept(64'h8000_03F0, 1'b0, 1'b1, 1'b0);
        ar_phase(0, 64'h8000_03F0, 8'd1);
        beat(64'hC0C0, 2'b00, 1'b0, 0);
        beat(64'hD0D0, 2'b00, 1'b1, 2);
        check("g_refresh", refresh, 1'b1);
        check("g_line_we", line_we, 2'b01);
        check("g_line_data", line_data, {64'hD0D0, 64'hC0C0});
        check("g_line_index", line_index, 6'h3F);
        step();
        check("g_refresh_once", refresh, 1'b0);

        // reset in R state, then clean restart
        accept(64'h2000_0040, 1'b0, 1'b1, 1'b0);
        ar_phase(0, 64'h2000_0040, 8'd1);
        beat(64'hE, 2'b00, 1'b0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("r_busy", busy, 1'b0);
        check("r_rready", rready, 1'b0);
        check("r_pulses", {refresh, uc_valid, bus_err, arvalid}, 4'b0);
        accept(64'h2000_0088, 1'b1, 1'b1, 1'b0);
        ar_phase(0, 64'h2000_0080, 8'd1);
        beat(64'h77, 2'b00, 1'b0, 0);
        beat(64'h88, 2'b00, 1'b1, 0);
        check("r_refresh", refresh, 1'b1);
        check("r_line_we", line_we, 2'b10);
        check("r_line_data", line_data, {64'h88, 64'h77});
        step();

        // flush coincident with request: not accepted
        miss = 1'b1; flush = 1'b1; req_addr = 64'h4000_0000;
        step();
        miss = 1'b0; flush = 1'b0;
        check("fr_busy", busy, 1'b0);
        check("fr_arvalid", arvalid, 1'b0);

        // miss and uc_req together: cached wins
        accept(64'h3000_0018, 1'b0, 1'b1, 1'b1);
        ar_phase(0, 64'h3000_0010, 8'd1);
        beat(64'h5, 2'b00, 1'b0, 0);
        beat(64'h6, 2'b00, 1'b1, 0);
        check("p_refresh", {refresh, uc_valid}, 2'b10);
        check("p_line_we", line_we, 2'b01);
        step();
        check("p_after_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
